// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and source encodings for the register-file write-back path.
// The register file uses the same data and address widths.
package rf_wb_arbiter_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 2 ** AW;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register busy scoreboard: the issue stage reserves destinations, and the
// write port releases them on the edge where the register file stores the data.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int AW = rf_wb_arbiter_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_vld_i,
  input  logic [AW-1:0]     issue_add_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_add_i,
  input  logic [AW-1:0]     add1_i,
  input  logic [AW-1:0]     add2_i,
  output logic              issue_rdy_o,
  output logic              haz_o,
  output logic [2**AW-1:0]  busy_o
);

  logic [2**AW-1:0] busy_q, busy_d;
  logic             issueRdy;

  assign issueRdy    = ~busy_q[issue_add_i];
  assign issue_rdy_o = issueRdy;
  assign haz_o       = busy_q[add1_i] | busy_q[add2_i];
  assign busy_o      = busy_q;

  // The set is applied after the clear so a same-edge reservation survives.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_add_i] = 1'b0;
    end
    if (issue_vld_i && issueRdy) begin
      busy_d[issue_add_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter between the ALU (A) and load unit (B), driving
// a registered register-file write port and the busy scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW = rf_wb_arbiter_pkg::DW,
  parameter int AW = rf_wb_arbiter_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_vld_i,
  input  logic [AW-1:0]     a_add_i,
  input  logic [DW-1:0]     a_data_i,
  output logic              a_rdy_o,
  input  logic              b_vld_i,
  input  logic [AW-1:0]     b_add_i,
  input  logic [DW-1:0]     b_data_i,
  output logic              b_rdy_o,
  input  logic              freeze_i,
  input  logic              issue_vld_i,
  input  logic [AW-1:0]     issue_add_i,
  output logic              issue_rdy_o,
  input  logic [AW-1:0]     add1_i,
  input  logic [AW-1:0]     add2_i,
  output logic              haz_o,
  output logic [2**AW-1:0]  busy_o,
  output logic [AW-1:0]     wadd_o,
  output logic              wen_o,
  output logic [DW-1:0]     datain_o
);

  logic          grantA, grantB;
  logic          wen_q, wen_d;
  logic [AW-1:0] wadd_q, wadd_d;
  logic [DW-1:0] datain_q, datain_d;
  src_e          last_q, last_d;

  // On a conflict the source that did not win last time is granted.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (!freeze_i) begin
      if (a_vld_i && b_vld_i) begin
        grantA = (last_q == SRC_B);
        grantB = (last_q == SRC_A);
      end else begin
        grantA = a_vld_i;
        grantB = b_vld_i;
      end
    end
  end

  always_comb begin
    wen_d    = 1'b0;
    wadd_d   = wadd_q;
    datain_d = datain_q;
    last_d   = last_q;
    if (grantA) begin
      wen_d    = 1'b1;
      wadd_d   = a_add_i;
      datain_d = a_data_i;
      last_d   = SRC_A;
    end else if (grantB) begin
      wen_d    = 1'b1;
      wadd_d   = b_add_i;
      datain_d = b_data_i;
      last_d   = SRC_B;
    end
  end

  // LAST resets to B so that A wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q    <= 1'b0;
      wadd_q   <= '0;
      datain_q <= '0;
      last_q   <= SRC_B;
    end else begin
      wen_q    <= wen_d;
      wadd_q   <= wadd_d;
      datain_q <= datain_d;
      last_q   <= last_d;
    end
  end

  assign a_rdy_o  = grantA;
  assign b_rdy_o  = grantB;
  assign wen_o    = wen_q;
  assign wadd_o   = wadd_q;
  assign datain_o = datain_q;

  rf_scoreboard #(
    .AW(AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_vld_i(issue_vld_i),
    .issue_add_i(issue_add_i),
    .clr_en_i   (wen_q),
    .clr_add_i  (wadd_q),
    .add1_i     (add1_i),
    .add2_i     (add2_i),
    .issue_rdy_o(issue_rdy_o),
    .haz_o      (haz_o),
    .busy_o     (busy_o)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, reset
// corner sequences, then randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

  typedef struct {
    logic        aVld;
    logic [2:0]  aAdd;
    logic [15:0] aData;
    logic        bVld;
    logic [2:0]  bAdd;
    logic [15:0] bData;
    logic        frz;
    logic        iVld;
    logic [2:0]  iAdd;
    logic [2:0]  add1;
    logic [2:0]  add2;
    logic        aRdy;
    logic        bRdy;
    logic        iRdy;
    logic        haz;
    logic        wen;
    logic [2:0]  wadd;
    logic [15:0] data;
    logic [7:0]  busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aVld, bVld, freeze, issueVld;
  logic [2:0]  aAdd, bAdd, issueAdd, add1, add2;
  logic [15:0] aData, bData;
  logic        aRdy, bRdy, issueRdy, haz, wen;
  logic [7:0]  busy;
  logic [2:0]  wadd;
  logic [15:0] datain;

  int checks = 0;
  int errors = 0;

  // Behavioural model: last winner, write-port contents and busy bits.
  int         mLastWinner;
  bit         mWen;
  int         mWadd;
  int         mData;
  bit         mBusy[8];
  bit         mGrantA, mGrantB;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_vld_i    (aVld),
    .a_add_i    (aAdd),
    .a_data_i   (aData),
    .a_rdy_o    (aRdy),
    .b_vld_i    (bVld),
    .b_add_i    (bAdd),
    .b_data_i   (bData),
    .b_rdy_o    (bRdy),
    .freeze_i   (freeze),
    .issue_vld_i(issueVld),
    .issue_add_i(issueAdd),
    .issue_rdy_o(issueRdy),
    .add1_i     (add1),
    .add2_i     (add2),
    .haz_o      (haz),
    .busy_o     (busy),
    .wadd_o     (wadd),
    .wen_o      (wen),
    .datain_o   (datain)
  );

  function automatic logic [7:0] modelBusyVec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = mBusy[i];
    return v;
  endfunction

  task automatic resetModel();
    mLastWinner = 1;
    mWen = 0;
    mWadd = 0;
    mData = 0;
    for (int i = 0; i < 8; i++) mBusy[i] = 0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, checks combinational outputs mid-cycle and the
  // registered outputs just after the edge. Expected values come from the
  // vector itself unless fromModel is set.
  task automatic applyStimulus(input vec_t v, input bit fromModel, input string tag);
    bit mIrdy, mHaz, wantA, wantB;
    aVld = v.aVld; aAdd = v.aAdd; aData = v.aData;
    bVld = v.bVld; bAdd = v.bAdd; bData = v.bData;
    freeze = v.frz; issueVld = v.iVld; issueAdd = v.iAdd;
    add1 = v.add1; add2 = v.add2;
    @(negedge clk);
    wantA = v.aVld && !v.frz;
    wantB = v.bVld && !v.frz;
    if (wantA && wantB) begin
      mGrantA = (mLastWinner == 1);
      mGrantB = (mLastWinner == 0);
    end else begin
      mGrantA = wantA;
      mGrantB = wantB;
    end
    mIrdy = !mBusy[v.iAdd];
    mHaz  = mBusy[v.add1] || mBusy[v.add2];
    if (fromModel) begin
      v.aRdy = mGrantA; v.bRdy = mGrantB; v.iRdy = mIrdy; v.haz = mHaz;
    end
    checkOutput({tag, " a_rdy"}, {15'd0, aRdy}, {15'd0, v.aRdy});
    checkOutput({tag, " b_rdy"}, {15'd0, bRdy}, {15'd0, v.bRdy});
    checkOutput({tag, " issue_rdy"}, {15'd0, issueRdy}, {15'd0, v.iRdy});
    checkOutput({tag, " haz"}, {15'd0, haz}, {15'd0, v.haz});
    @(posedge clk);
    if (mWen) mBusy[mWadd] = 0;
    if (v.iVld && mIrdy) mBusy[v.iAdd] = 1;
    if (mGrantA) begin
      mWen = 1; mWadd = v.aAdd; mData = v.aData; mLastWinner = 0;
    end else if (mGrantB) begin
      mWen = 1; mWadd = v.bAdd; mData = v.bData; mLastWinner = 1;
    end else begin
      mWen = 0;
    end
    #1;
    if (fromModel) begin
      v.wen = mWen; v.wadd = 3'(mWadd); v.data = 16'(mData); v.busy = modelBusyVec();
    end
    checkOutput({tag, " wen"}, {15'd0, wen}, {15'd0, v.wen});
    checkOutput({tag, " wadd"}, {13'd0, wadd}, {13'd0, v.wadd});
    checkOutput({tag, " datain"}, datain, v.data);
    checkOutput({tag, " busy"}, {8'd0, busy}, {8'd0, v.busy});
  endtask

  initial begin
    vec_t v;
    bit aPend, bPend;
    logic [2:0] aPAdd, bPAdd;
    logic [15:0] aPData, bPData;

    //            aV aA aData     bV bA bData     fz iV iA a1 a2  aR bR iR hz  wen wa data     busy
    tbl.push_back('{1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 1, 0, 1, 0, 1, 3, 16'h1234, 8'h00});
    tbl.push_back('{0, 0, 16'h0000, 1, 6, 16'h0606, 0, 0, 0, 3, 0, 0, 1, 1, 0, 1, 6, 16'h0606, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 16'hAAAA, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 16'hBBBB, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 16'hAAAA, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 16'hBBBB, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 16'hBBBB, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 16'hBBBB, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 16'hBBBB, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 16'hAAAA, 8'h00});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 5, 0, 0, 0, 1, 0, 0, 1, 16'hAAAA, 8'h20});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 5, 0, 0, 0, 0, 1, 0, 1, 16'hAAAA, 8'h20});
    tbl.push_back('{1, 5, 16'h5555, 0, 0, 16'h0000, 0, 0, 5, 0, 5, 1, 0, 0, 1, 1, 5, 16'h5555, 8'h20});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 5, 0, 0, 0, 0, 1, 0, 5, 16'h5555, 8'h00});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 5, 0, 0, 0, 1, 0, 0, 5, 16'h5555, 8'h00});
    tbl.push_back('{1, 4, 16'h4444, 0, 0, 16'h0000, 0, 0, 4, 0, 0, 1, 0, 1, 0, 1, 4, 16'h4444, 8'h00});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 4, 4, 0, 0, 0, 1, 0, 0, 4, 16'h4444, 8'h10});
    tbl.push_back('{0, 0, 16'h0000, 1, 7, 16'h7777, 0, 0, 4, 4, 7, 0, 1, 0, 1, 1, 7, 16'h7777, 8'h10});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 4, 7, 0, 0, 0, 1, 0, 7, 16'h7777, 8'h10});
    tbl.push_back('{1, 4, 16'h0F0F, 0, 0, 16'h0000, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 4, 16'h0F0F, 8'h10});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 4, 16'h0F0F, 8'h00});
    tbl.push_back('{1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 4, 0, 0, 0, 1, 1, 0, 1, 2, 16'hBBBB, 8'h00});

    rst_n = 1'b0;
    aVld = 1; aAdd = 3; aData = 16'h1234;
    bVld = 0; bAdd = 0; bData = 0;
    freeze = 0; issueVld = 0; issueAdd = 0; add1 = 0; add2 = 0;
    resetModel();
    #3;
    checkOutput("reset wen", {15'd0, wen}, 16'd0);
    checkOutput("reset busy", {8'd0, busy}, 16'd0);
    checkOutput("reset a_rdy", {15'd0, aRdy}, 16'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Reset asserted right after a write has been registered must drop it.
    aVld = 1; aAdd = 6; aData = 16'h6666; bVld = 0; freeze = 0;
    issueVld = 1; issueAdd = 3;
    @(posedge clk);
    #1;
    checkOutput("midreset pre wen", {15'd0, wen}, 16'd1);
    checkOutput("midreset pre busy", {8'd0, busy}, 16'h0008);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset wen", {15'd0, wen}, 16'd0);
    checkOutput("midreset busy", {8'd0, busy}, 16'd0);
    checkOutput("midreset wadd", {13'd0, wadd}, 16'd0);
    checkOutput("midreset datain", datain, 16'd0);
    aVld = 0; issueVld = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    resetModel();

    aPend = 0; bPend = 0;
    aPAdd = 0; bPAdd = 0; aPData = 0; bPData = 0;
    for (int n = 0; n < 300; n++) begin
      if (!aPend && ($urandom_range(0, 1) == 1)) begin
        aPend = 1; aPAdd = 3'($urandom_range(0, 7)); aPData = 16'($urandom);
      end
      if (!bPend && ($urandom_range(0, 1) == 1)) begin
        bPend = 1; bPAdd = 3'($urandom_range(0, 7)); bPData = 16'($urandom);
      end
      v = '{aPend, aPAdd, aPData, bPend, bPAdd, bPData,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            0, 0, 0, 0, 0, 0, 16'd0, 8'd0};
      applyStimulus(v, 1'b1, $sformatf("rnd%0d", n));
      if (mGrantA) aPend = 0;
      if (mGrantB) bPend = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back controller for the 8 x 16-bit register file, which has a single write port (WADD/WEN/DATAIN).
- Arbitrates between two write-back sources, A (ALU) and B (load unit), using valid/ready handshakes and round-robin priority.
- Drives a registered write port into the register file.
- Keeps a per-register busy scoreboard so issue logic can detect RAW and WAW hazards on the two read addresses and the destination.

Parameters:
- DW, 16, data width of register file entries.
- AW, 3, register address width (2**AW registers).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- A_VLD  in  1  source A has a write pending.
- A_ADD  in  AW  source A destination register.
- A_DATA  in  DW  source A write data.
- A_RDY  out  1  source A write accepted this cycle.
- B_VLD  in  1  source B has a write pending.
- B_ADD  in  AW  source B destination register.
- B_DATA  in  DW  source B write data.
- B_RDY  out  1  source B write accepted this cycle.
- FREEZE  in  1  blocks all grants while high.
- ISSUE_VLD  in  1  issue stage reserves a destination register.
- ISSUE_ADD  in  AW  destination being reserved.
- ISSUE_RDY  out  1  reservation accepted (no WAW hazard).
- ADD1  in  AW  read address 1, same as the register file read address.
- ADD2  in  AW  read address 2.
- HAZ  out  1  ADD1 or ADD2 targets a busy register.
- BUSY  out  2**AW  scoreboard, one bit per register.
- WADD  out  AW  to register file WADD.
- WEN  out  1  to register file WEN.
- DATAIN  out  DW  to register file DATAIN.

Behaviour:
- Reset (RST_N low, asynchronous):
  - WEN=0, WADD=0, DATAIN=0, BUSY=0.
  - Round-robin pointer LAST=B, so A wins the first conflict.
  - Release is synchronous to CLK.
- Arbitration (combinational, same cycle):
  - No grant while FREEZE=1.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the source not equal to LAST.
  - A_RDY = grant A; B_RDY = grant B. The two are never high together.
  - A source holds VLD/ADD/DATA stable until its RDY is high.
- Handshake/commit:
  - A transfer occurs when VLD & RDY at a rising edge.
  - On that edge WEN<=1, WADD<=granted ADD, DATAIN<=granted DATA, LAST<=granted source.
  - No transfer on an edge: WEN<=0, and WADD/DATAIN hold their values.
  - The register file captures the write on the following edge, so latency is 1 cycle to the write-port outputs and 2 edges to storage.
  - Throughput is one write per cycle.
- Scoreboard:
  - Reservation edge: ISSUE_VLD & ISSUE_RDY sets BUSY[ISSUE_ADD].
  - Clear edge: BUSY[WADD] clears on each edge where WEN=1, the edge the register file stores the data.
  - Same register set and cleared on the same edge: set wins.
  - ISSUE_RDY = ~BUSY[ISSUE_ADD] (combinational). A reservation is held off until the outstanding write commits.
  - HAZ = BUSY[ADD1] | BUSY[ADD2] (combinational).
- Boundary cases:
  - A write to a non-busy register is still performed; BUSY stays 0, and no error is raised.
  - FREEZE has no effect on a write already registered: WEN still pulses.
  - Asserting reset mid-transfer drops the pending registered write, since WEN is forced to 0, and clears all BUSY bits.

Decomposition:
- Shared package holds:
  - DW/AW constants, also used by the register file.
  - SRC_A=1'b0 and SRC_B=1'b1 encodings for LAST.
- One natural sub-module, rf_scoreboard: the BUSY vector with set/clear/priority, ISSUE_RDY and HAZ.
- Arbitration and the write-port register stay in the top level.

Test Plan:
- Reset: hold RST_N=0 with A_VLD=1 -> WEN=0, BUSY=8'h00, A_RDY=1 combinationally. Release -> first edge gives WEN=1, WADD=A_ADD.
- Single source: A_VLD=1, A_ADD=3, A_DATA=16'h1234 for one cycle -> next cycle WEN=1, WADD=3, DATAIN=16'h1234. Reading ADD1=3 afterwards returns 16'h1234 from the register file.
- Conflict: A and B valid continuously, A_ADD=1, B_ADD=2 -> grants alternate A,B,A,B starting with A. WADD sequence is 1,2,1,2.
- FREEZE: both valid, FREEZE=1 for 3 cycles -> A_RDY=B_RDY=0 and WEN=0 for those cycles. Grants resume with the source opposite LAST.
- Scoreboard: issue ISSUE_ADD=5 -> BUSY=8'h20, and HAZ=1 with ADD1=5. A second issue to 5 gives ISSUE_RDY=0. After the write to 5 commits, BUSY=0 and ISSUE_RDY=1.
- Set/clear collision: WEN=1 with WADD=4 on the same edge as an issue to 4 (BUSY[4] was 0) -> BUSY[4]=1 after the edge.
